// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM generator with shadowed duty handshake
// Counts synchronized tick_in edges; duty updates are double-buffered and applied only at the period wrap.
module tick_pwm #(
  parameter int CNT_WIDTH  = 8,
  parameter int PERIOD_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic [CNT_WIDTH-1:0] duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic                 pwm_out,
  output logic                 period_start
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(PERIOD_MAX);
  localparam logic [CNT_WIDTH:0]   DUTY_FULL = (CNT_WIDTH+1)'(PERIOD_MAX + 1);

  logic                 s1, s2, s3;
  logic                 tick;
  logic                 wrap;
  logic                 xfer;

  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [CNT_WIDTH-1:0] duty_active, duty_active_next;
  logic [CNT_WIDTH-1:0] shadow, shadow_next;
  logic                 shadow_full, shadow_full_next;
  logic [CNT_WIDTH:0]   duty_ext;
  logic [CNT_WIDTH:0]   duty_eff;
  logic                 pwm_next;

  // tick_in is asynchronous: two sync flops, then s3 as history for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick       = s2 & ~s3;
  assign wrap       = tick && (cnt == CNT_LAST);
  assign duty_ready = ~shadow_full;
  assign xfer       = duty_valid && duty_ready;

  always_comb begin
    cnt_next         = cnt;
    duty_active_next = duty_active;
    shadow_next      = shadow;
    shadow_full_next = shadow_full;

    if (tick) begin
      cnt_next = wrap ? '0 : cnt + 1'b1;
    end

    // Only a value already sitting in the shadow is promoted; a transfer on
    // the wrap edge itself waits for the following wrap.
    if (wrap && shadow_full) begin
      duty_active_next = shadow;
      shadow_full_next = 1'b0;
    end

    if (xfer) begin
      shadow_next      = duty_in;
      shadow_full_next = 1'b1;
    end
  end

  // Clamp to a full period so oversized duties stay high across the wrap
  always_comb begin
    duty_ext = {1'b0, duty_active_next};
    duty_eff = (duty_ext > DUTY_FULL) ? DUTY_FULL : duty_ext;
    pwm_next = ({1'b0, cnt_next} < duty_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      duty_active  <= '0;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      duty_active  <= duty_active_next;
      shadow       <= shadow_next;
      shadow_full  <= shadow_full_next;
      pwm_out      <= pwm_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_tick_pwm.sv
// tb/tb_tick_pwm.sv - directed self-checking bench for tick_pwm (PERIOD_MAX=3, CNT_WIDTH=4)
module tb_tick_pwm;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_start;

  int nvec;
  int nerr;
  int ps_count;
  int watch;
  int viol;
  int ps_before;

  tick_pwm #(.CNT_WIDTH(4), .PERIOD_MAX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watch: 1 = pwm must stay low, 2 = pwm must stay high
  always @(negedge clk) begin
    if (period_start === 1'b1) ps_count++;
    if (watch == 1 && pwm_out !== 1'b0) viol++;
    if (watch == 2 && pwm_out !== 1'b1) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick_in pulse; cnt/pwm update on the third rising edge. Optional
  // transfer aligned to that same (wrap) edge.
  task automatic tick_once(input bit xfer, input logic [3:0] val);
    tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (xfer) begin
      duty_in    = val;
      duty_valid = 1'b1;
    end
    @(negedge clk);
    if (xfer) duty_valid = 1'b0;
    tick_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic tick_chk(input logic [3:0] ecnt, input logic epwm);
    tick_once(1'b0, 4'd0);
    check("cnt", 32'(dut.cnt), 32'(ecnt));
    check("pwm", 32'(pwm_out), 32'(epwm));
  endtask

  task automatic send_duty(input logic [3:0] val);
    duty_in    = val;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    check("ready_after_xfer", 32'(duty_ready), 32'd0);
  endtask

  initial begin
    nvec = 0; nerr = 0; ps_count = 0; watch = 0; viol = 0;
    rst = 1'b0; tick_in = 1'b0; duty_in = '0; duty_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnt", 32'(dut.cnt), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_ready", 32'(duty_ready), 32'd1);
    check("rst_ps", 32'(period_start), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Long tick_in high level: one increment, two clks after s1 capture
    tick_in = 1'b1;
    @(negedge clk);
    check("lat_s1", 32'(dut.cnt), 32'd0);
    @(negedge clk);
    check("lat_s2", 32'(dut.cnt), 32'd0);
    @(negedge clk);
    check("lat_cnt", 32'(dut.cnt), 32'd1);
    repeat (17) @(negedge clk);
    check("level_one_tick", 32'(dut.cnt), 32'd1);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);

    // Duty 2 sent mid-period, applied at wrap: pattern 1100
    send_duty(4'd2);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    ps_before = ps_count;
    tick_chk(4'd0, 1'b1);
    check("ps_once", 32'(ps_count - ps_before), 32'd1);
    check("ready_after_wrap", 32'(duty_ready), 32'd1);
    tick_chk(4'd1, 1'b1);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b1);

    // Duty 0 gives a low period, then duty 9 stays high across wraps
    send_duty(4'd0);
    tick_chk(4'd1, 1'b1);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b0);
    watch = 1;
    tick_chk(4'd1, 1'b0);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    send_duty(4'd9);
    watch = 0;
    tick_chk(4'd0, 1'b1);
    watch = 2;
    tick_chk(4'd1, 1'b1);
    tick_chk(4'd2, 1'b1);
    tick_chk(4'd3, 1'b1);
    tick_chk(4'd0, 1'b1);
    tick_chk(4'd1, 1'b1);
    watch = 0;
    check("no_glitch", 32'(viol), 32'd0);

    // Second value held while shadow full: captured only after the wrap
    send_duty(4'd1);
    duty_in    = 4'd3;
    duty_valid = 1'b1;
    @(negedge clk);
    check("held_not_ready", 32'(duty_ready), 32'd0);
    tick_chk(4'd2, 1'b1);
    tick_chk(4'd3, 1'b1);
    tick_chk(4'd0, 1'b1);
    check("held_captured", 32'(duty_ready), 32'd0);
    duty_valid = 1'b0;
    tick_chk(4'd1, 1'b0);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b1);
    tick_chk(4'd1, 1'b1);
    tick_chk(4'd2, 1'b1);
    tick_chk(4'd3, 1'b0);

    // Transfer on the exact wrap edge must not bypass into the active duty
    tick_once(1'b1, 4'd0);
    check("wx_cnt", 32'(dut.cnt), 32'd0);
    check("wx_pwm", 32'(pwm_out), 32'd1);
    check("wx_ready", 32'(duty_ready), 32'd0);
    tick_chk(4'd1, 1'b1);
    tick_chk(4'd2, 1'b1);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b0);
    check("wx_ready_rise", 32'(duty_ready), 32'd1);

    // Mid-period reset pulse with duty 2 active and a value in the shadow
    send_duty(4'd2);
    tick_chk(4'd1, 1'b0);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b1);
    tick_chk(4'd1, 1'b1);
    send_duty(4'd3);
    rst = 1'b0;
    #0.5;
    check("ar_cnt", 32'(dut.cnt), 32'd0);
    check("ar_pwm", 32'(pwm_out), 32'd0);
    check("ar_ready", 32'(duty_ready), 32'd1);
    check("ar_ps", 32'(period_start), 32'd0);
    check("ar_duty", 32'(dut.duty_active), 32'd0);
    #0.5;
    rst = 1'b1;
    @(negedge clk);
    tick_chk(4'd1, 1'b0);
    tick_chk(4'd2, 1'b0);
    tick_chk(4'd3, 1'b0);
    tick_chk(4'd0, 1'b0);
    tick_chk(4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
